// File: rtl/dds.sv
// -----------------------------------------------------------------------------
// dds : direct digital synthesizer and baseband modulator.
//
// A 32-bit phase accumulator (acc) advances by a fixed PHASE_INC derived from
// FREQ_CLK / FREQ_OUT. It addresses a quarter-wave sine table to produce
// sine, cosine, saw and square test tones, and the ASK / BPSK / QPSK / RAW
// modulations keyed by `data`. A second accumulator (fsk_acc), advanced by the
// externally supplied fsk_phase_inc, produces the FSK tone.
//
// Optional feature macro: DDS_QPSK_EN
//   defined   -> mode 12 produces QPSK, S(a + 64*data)
//   undefined -> QPSK logic is absent and mode 12 outputs 0
//
// Parameters:
//   FREQ_CLK       clock frequency in Hz
//   FREQ_OUT       carrier frequency in Hz
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset (priority over en)
//   en             clock enable; low freezes accumulators and output
//   mode   [3:0]   waveform / modulation select
//   data   [1:0]   modulating symbol (bit 1 used only by QPSK)
//   fsk_phase_inc  FSK accumulator increment per enabled cycle
//   wave   [11:0]  registered signed output sample, one cycle latency
// -----------------------------------------------------------------------------
module dds #(
  parameter int unsigned FREQ_CLK = 50_000_000,
  parameter int unsigned FREQ_OUT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         mode,
  input  logic [1:0]         data,
  input  logic [31:0]        fsk_phase_inc,
  output logic signed [11:0] wave
);

  // Rounded 2^32 * FREQ_OUT / FREQ_CLK, computed in 64 bits.
  localparam logic [63:0] PHASE_INC_64 =
    ((64'd1 << 32) * 64'(FREQ_OUT) + 64'(FREQ_CLK / 2)) / 64'(FREQ_CLK);
  localparam logic [31:0] PHASE_INC = PHASE_INC_64[31:0];

  typedef enum logic [3:0] {
    MODE_SINE   = 4'd0,
    MODE_COSINE = 4'd1,
    MODE_SAW    = 4'd2,
    MODE_SQUARE = 4'd3,
    MODE_ASK    = 4'd8,
    MODE_FSK    = 4'd9,
    MODE_BPSK   = 4'd10,
    MODE_RAW    = 4'd11,
    MODE_QPSK   = 4'd12
  } mode_e;

  // First quadrant, index 0..64: round(2047 * sin(2*pi*i/256)).
  function automatic logic [10:0] quarter_sin(input logic [6:0] idx);
    case (idx)
      7'd0:  return 11'd0;    7'd1:  return 11'd50;   7'd2:  return 11'd100;
      7'd3:  return 11'd151;  7'd4:  return 11'd201;  7'd5:  return 11'd251;
      7'd6:  return 11'd300;  7'd7:  return 11'd350;  7'd8:  return 11'd399;
      7'd9:  return 11'd449;  7'd10: return 11'd497;  7'd11: return 11'd546;
      7'd12: return 11'd594;  7'd13: return 11'd642;  7'd14: return 11'd690;
      7'd15: return 11'd737;  7'd16: return 11'd783;  7'd17: return 11'd830;
      7'd18: return 11'd875;  7'd19: return 11'd920;  7'd20: return 11'd965;
      7'd21: return 11'd1009; 7'd22: return 11'd1052; 7'd23: return 11'd1095;
      7'd24: return 11'd1137; 7'd25: return 11'd1179; 7'd26: return 11'd1219;
      7'd27: return 11'd1259; 7'd28: return 11'd1299; 7'd29: return 11'd1337;
      7'd30: return 11'd1375; 7'd31: return 11'd1411; 7'd32: return 11'd1447;
      7'd33: return 11'd1483; 7'd34: return 11'd1517; 7'd35: return 11'd1550;
      7'd36: return 11'd1582; 7'd37: return 11'd1614; 7'd38: return 11'd1644;
      7'd39: return 11'd1674; 7'd40: return 11'd1702; 7'd41: return 11'd1729;
      7'd42: return 11'd1756; 7'd43: return 11'd1781; 7'd44: return 11'd1805;
      7'd45: return 11'd1828; 7'd46: return 11'd1850; 7'd47: return 11'd1871;
      7'd48: return 11'd1891; 7'd49: return 11'd1910; 7'd50: return 11'd1927;
      7'd51: return 11'd1944; 7'd52: return 11'd1959; 7'd53: return 11'd1973;
      7'd54: return 11'd1986; 7'd55: return 11'd1997; 7'd56: return 11'd2008;
      7'd57: return 11'd2017; 7'd58: return 11'd2025; 7'd59: return 11'd2032;
      7'd60: return 11'd2037; 7'd61: return 11'd2041; 7'd62: return 11'd2045;
      7'd63: return 11'd2046; 7'd64: return 11'd2047;
      default: return 11'd0;
    endcase
  endfunction

  // Full 256-entry sine by quadrant symmetry: quadrants 1 and 3 mirror the
  // index, quadrants 2 and 3 negate. Range is +-2047 so negation is safe.
  function automatic logic signed [11:0] sine_lut(input logic [7:0] x);
    logic [6:0]  idx;
    logic [11:0] mag;
    idx = x[6] ? (7'd64 - {1'b0, x[5:0]}) : {1'b0, x[5:0]};
    mag = {1'b0, quarter_sin(idx)};
    return x[7] ? -$signed(mag) : $signed(mag);
  endfunction

  logic [31:0]        acc;
  logic [31:0]        fsk_acc;
  logic [7:0]         a;
  logic signed [11:0] sin_a;
  logic signed [11:0] next_wave;

  assign a     = acc[31:24];
  assign sin_a = sine_lut(a);

`ifndef DDS_QPSK_EN
  // data[1] only feeds QPSK; keep it visibly consumed when QPSK is absent.
  logic data_unused;
  assign data_unused = data[1];
`endif

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_wave = '0;
    case (mode)
      MODE_SINE:   next_wave = sin_a;
      MODE_COSINE: next_wave = sine_lut(a + 8'd64);
      MODE_SAW:    next_wave = $signed(acc[31:20] ^ 12'h800);
      MODE_SQUARE: next_wave = acc[31] ? -12'sd2047 : 12'sd2047;
      MODE_ASK:    next_wave = data[0] ? sin_a : 12'sd0;
      MODE_FSK:    next_wave = sine_lut(fsk_acc[31:24]);
      MODE_BPSK:   next_wave = data[0] ? -sin_a : sin_a;
      MODE_RAW:    next_wave = data[0] ? 12'sd2047 : -12'sd2047;
`ifdef DDS_QPSK_EN
      MODE_QPSK:   next_wave = sine_lut(a + {data, 6'b0});
`endif
      default:     next_wave = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of acc / fsk_acc, giving the one-cycle
  // latency between phase and sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      fsk_acc <= '0;
      wave    <= '0;
    end else if (en) begin
      acc     <= acc + PHASE_INC;
      fsk_acc <= fsk_acc + fsk_phase_inc;
      wave    <= next_wave;
    end
  end

endmodule

// File: tb/tb_dds.sv
// -----------------------------------------------------------------------------
// tb_dds : self-checking bench for dds with FREQ_CLK = 300, FREQ_OUT = 1.
// A behavioural model builds the sine table from $sin and derives the phase
// from the count of enabled cycles; a negedge process compares every sample
// against it, and directed checks pin hand-computed values.
// -----------------------------------------------------------------------------
module tb_dds;

  localparam int unsigned FREQ_CLK = 300;
  localparam int unsigned FREQ_OUT = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [3:0]         mode;
  logic [1:0]         data;
  logic [31:0]        fsk_phase_inc;
  logic signed [11:0] wave;

  always #5 clk = ~clk;

  dds #(.FREQ_CLK(FREQ_CLK), .FREQ_OUT(FREQ_OUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .mode          (mode),
    .data          (data),
    .fsk_phase_inc (fsk_phase_inc),
    .wave          (wave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint pinc;
  int     lut[256];

  initial begin
    pinc = (((64'd1 << 32) * longint'(FREQ_OUT)) + longint'(FREQ_CLK / 2))
           / longint'(FREQ_CLK);
    for (int i = 0; i < 256; i++) begin
      real v;
      v = 2047.0 * $sin(2.0 * 3.14159265358979323846 * i / 256.0);
      lut[i] = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
    end
  end

  function automatic int model_wave(input logic [31:0] acc,
                                    input logic [31:0] facc,
                                    input logic [3:0] m, input logic [1:0] d);
    int ph;
    ph = int'(acc[31:24]);
    case (m)
      4'd0:  return lut[ph];
      4'd1:  return lut[(ph + 64) % 256];
      4'd2:  return int'(acc[31:20]) - 2048;
      4'd3:  return acc[31] ? -2047 : 2047;
      4'd8:  return d[0] ? lut[ph] : 0;
      4'd9:  return lut[int'(facc[31:24])];
      4'd10: return d[0] ? -lut[ph] : lut[ph];
      4'd11: return d[0] ? 2047 : -2047;
`ifdef DDS_QPSK_EN
      4'd12: return lut[(ph + 64 * int'(d)) % 256];
`endif
      default: return 0;
    endcase
  endfunction

  longint      m_n;       // enabled cycles since reset
  logic [31:0] m_fsk;
  int          exp_wave;
  bit          check_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_n      <= 0;
      m_fsk    <= '0;
      exp_wave <= 0;
    end else if (en) begin
      exp_wave <= model_wave(32'(m_n * pinc), m_fsk, mode, data);
      m_n      <= m_n + 1;
      m_fsk    <= m_fsk + fsk_phase_inc;
    end
  end

  always @(negedge clk) begin
    if (check_en) check("stream", wave, exp_wave);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [3:0] m, input logic [1:0] d);
    rst  = 1'b1;
    mode = m;
    data = d;
    step(1);
    rst  = 1'b0;
  endtask

  int qpsk_exp[4];

  initial begin
    rst = 1'b1; en = 1'b0; mode = 4'd0; data = 2'd0; fsk_phase_inc = '0;
`ifdef DDS_QPSK_EN
    qpsk_exp = '{0, 2047, 0, -2047};
`else
    qpsk_exp = '{0, 0, 0, 0};
`endif
    #1;
    check("model_pinc", pinc, 14316558);
    check("model_lut0", lut[0], 0);
    check("model_lut64", lut[64], 2047);
    check("model_lut128", lut[128], 0);
    check("model_lut192", lut[192], -2047);

    step(2);
    check_en = 1'b1;
    check("reset_wave", wave, 0);

    // SINE: first sample, peak at a=64, freeze, resume, full period
    rst = 1'b0; en = 1'b1; mode = 4'd0;
    step(1);   check("sine_first", wave, 0);
    step(75);  check("sine_peak", wave, 2047);
    en = 1'b0;
    step(10);  check("freeze_hold", wave, 2047);
    en = 1'b1;
    step(1);   check("freeze_resume", wave, 2047);
    step(224); check("sine_period", wave, 0);

    // reset pulse mid-run restarts phase
    step(20);
    rst = 1'b1;
    step(1);   check("rst_mid", wave, 0);
    rst = 1'b0;
    step(1);   check("rst_restart", wave, 0);
    step(75);  check("rst_peak", wave, 2047);

    do_reset(4'd1, 2'd0);
    step(1);   check("cos_first", wave, 2047);

    do_reset(4'd3, 2'd0);
    step(1);   check("sq_first", wave, 2047);
    step(149); check("sq_last_pos", wave, 2047);
    step(1);   check("sq_first_neg", wave, -2047);
    step(150); check("sq_wrap", wave, 2047);

    do_reset(4'd2, 2'd0);
    step(1);   check("saw_first", wave, -2048);
    step(299); check("saw_top", wave, 2034);
    step(1);   check("saw_wrap", wave, -2048);

    do_reset(4'd8, 2'd0);
    step(76);  check("ask_d0", wave, 0);
    data = 2'd1;
    step(1);   check("ask_d1", wave, 2047);

    do_reset(4'd10, 2'd1);
    step(76);  check("bpsk_d1", wave, -2047);
    data = 2'd0;
    step(1);   check("bpsk_d0", wave, 2047);

    do_reset(4'd11, 2'd0);
    step(1);   check("raw_d0", wave, -2047);
    data = 2'd1;
    step(1);   check("raw_d1", wave, 2047);

    fsk_phase_inc = 32'd71582789;
    do_reset(4'd9, 2'd0);
    step(1);   check("fsk5_first", wave, 0);
    step(15);  check("fsk5_peak", wave, 2047);
    step(285); check("fsk5_period", wave, 0);

    fsk_phase_inc = 32'd14316558;
    do_reset(4'd9, 2'd0);
    step(76);  check("fsk1_peak", wave, 2047);
    step(225); check("fsk1_period", wave, 0);

    for (int d = 0; d < 4; d++) begin
      do_reset(4'd12, 2'(d));
      step(1);
      check($sformatf("qpsk_d%0d", d), wave, qpsk_exp[d]);
    end

    do_reset(4'd5, 2'd1);
    step(10);  check("unused_mode", wave, 0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
